// File: rtl/regfile_ctx.sv
// General/label register file with combinational bypassed reads and a
// sequential general<->shadow save/restore engine for context switches.
module regfile_ctx #(
  parameter int WIDTH     = 8,
  parameter int NUM_GEN   = 8,
  parameter int NUM_LABEL = 8,
  parameter int COND_IDX  = 5,
  parameter int AW        = 3,
  parameter int LW        = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [AW-1:0]    rs1,
  input  logic [AW-1:0]    rs2,
  input  logic [AW-1:0]    rd,
  input  logic [WIDTH-1:0] write_data,
  input  logic             reg_write,
  input  logic             cond_write,
  input  logic             condition_bit,
  input  logic             label_read,
  input  logic             label_write,
  input  logic [LW-1:0]    label_rs,
  input  logic             save_req,
  input  logic             restore_req,
  output logic [WIDTH-1:0] regA_o,
  output logic [WIDTH-1:0] regB_o,
  output logic             busy,
  output logic             done
);

  localparam int GIW = (NUM_GEN > 1) ? $clog2(NUM_GEN) : 1;
  localparam int LIW = (NUM_LABEL > 1) ? $clog2(NUM_LABEL) : 1;
  localparam logic [AW-1:0]  COND_A = AW'(COND_IDX);
  localparam logic [GIW-1:0] COND_I = GIW'(COND_IDX);
  localparam logic [AW-1:0]  LAST_A = AW'(NUM_GEN - 1);

  typedef enum logic [1:0] {ST_IDLE, ST_SAVE, ST_RESTORE} state_t;

  state_t           state_q;
  logic [AW-1:0]    idx_q;
  logic             done_q;
  logic [WIDTH-1:0] gen_q  [NUM_GEN];
  logic [WIDTH-1:0] shad_q [NUM_GEN];
  logic [WIDTH-1:0] lab_q  [NUM_LABEL];

  logic [LW-1:0]    rd_lab;
  logic [WIDTH-1:0] lab_v;

  // Label writes reuse rd, resized to the label address width.
  assign rd_lab = LW'(rd);
  assign busy   = (state_q != ST_IDLE);
  assign done   = done_q;

  function automatic logic gen_ok(input logic [AW-1:0] a);
    return 32'(a) < NUM_GEN;
  endfunction

  function automatic logic lab_ok(input logic [LW-1:0] a);
    return 32'(a) < NUM_LABEL;
  endfunction

  function automatic logic [WIDTH-1:0] gen_port(input logic [AW-1:0] a);
    logic [WIDTH-1:0] v;
    v = (a != '0 && gen_ok(a)) ? gen_q[a[GIW-1:0]] : '0;
    if (!busy && cond_write && a == COND_A)
      v = WIDTH'(condition_bit);
    else if (!busy && reg_write && a == rd && a != '0 && gen_ok(a))
      v = write_data;
    return v;
  endfunction

  always_comb begin
    lab_v = lab_ok(label_rs) ? lab_q[label_rs[LIW-1:0]] : '0;
    if (!busy && label_write && lab_ok(label_rs) && label_rs == rd_lab)
      lab_v = write_data;
    regA_o = label_read ? lab_v : gen_port(rs1);
    regB_o = label_read ? lab_v : gen_port(rs2);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_GEN; i++) begin
        gen_q[i]  <= '0;
        shad_q[i] <= '0;
      end
      for (int i = 0; i < NUM_LABEL; i++) lab_q[i] <= '0;
      state_q <= ST_IDLE;
      idx_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        ST_IDLE: begin
          if (reg_write && rd != '0 && gen_ok(rd))
            gen_q[rd[GIW-1:0]] <= write_data;
          // Placed after the general write so the condition bit wins on COND_IDX.
          if (cond_write)
            gen_q[COND_I] <= WIDTH'(condition_bit);
          if (label_write && lab_ok(rd_lab))
            lab_q[rd_lab[LIW-1:0]] <= write_data;
          idx_q <= '0;
          if (save_req)
            state_q <= ST_SAVE;
          else if (restore_req)
            state_q <= ST_RESTORE;
        end
        ST_SAVE, ST_RESTORE: begin
          if (state_q == ST_SAVE)
            shad_q[idx_q[GIW-1:0]] <= gen_q[idx_q[GIW-1:0]];
          else
            gen_q[idx_q[GIW-1:0]] <= shad_q[idx_q[GIW-1:0]];
          idx_q <= idx_q + AW'(1);
          if (idx_q == LAST_A) begin
            state_q <= ST_IDLE;
            done_q  <= 1'b1;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule
